trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and exit for the CPU's CSR file.
- Samples the external interrupt line, waits for a safe pipeline point, then issues single-cycle intr / intr_end pulses with the matching pc_store.
- Drives the pipeline redirect that loads csr_pc (mtvec on entry, mepc on return).
- Handles WFI sleep and its wake-up; sits between the EX stage, the CSR block and the fetch redirect mux.

Parameters:
- XLEN, 32, PC / data width.
- WFI_TIMEOUT, 0, cycles before forced wake from WFI; 0 = never.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ext_irq  in  1  level external interrupt (DMA / watchdog)
- csr_meie  in  1  mie[11] from CSR
- csr_mie  in  1  mstatus.MIE from CSR
- csr_we  in  1  CSR instruction write this cycle
- ex_valid  in  1  valid instruction in EX
- ex_pc  in  XLEN  PC of EX instruction
- mret  in  1  EX instruction is MRET
- wfi  in  1  EX instruction is WFI
- pipe_stall  in  1  pipeline frozen (memory wait); no redirect allowed
- intr  out  1  trap-entry pulse to CSR
- intr_end  out  1  trap-return pulse to CSR
- pc_store  out  XLEN  PC handed to CSR (becomes mepc)
- redirect  out  1  flush IF/ID/EX and fetch from csr_pc
- wfi_sleep  out  1  hold fetch/issue while sleeping
- in_trap  out  1  handler active

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high. Reset (including mid-operation) forces state RUN, the WFI counter to 0, irq_q to 0, and all outputs to 0 (pc_store = 0).
- irq_q: one register stage on ext_irq. Define pend = irq_q & csr_meie & csr_mie. Define safe = ex_valid & !pipe_stall & !csr_we.
- All outputs are registered Moore decodes of state. pc_q is an internal XLEN register.
- RUN:
  - mret & safe -> RET, with pc_q = ex_pc + 4 (mod 2^XLEN).
  - else pend -> PEND.
  - else wfi & safe -> SLEEP.
  - Priority: mret > pend > wfi.
- PEND:
  - safe -> TRAP, with pc_q = ex_pc.
  - pend dropping before safe -> RUN (interrupt withdrawn, no trap).
- TRAP: exactly one cycle. intr = 1, redirect = 1, pc_store = pc_q -> HANDLER.
- HANDLER: in_trap = 1.
  - mret & safe -> RET, with pc_q = ex_pc + 4.
  - irq is ignored (CSR has cleared MIE); no nesting.
- RET: exactly one cycle. intr_end = 1, redirect = 1, pc_store = pc_q -> RUN.
- SLEEP: wfi_sleep = 1.
  - irq_q & csr_meie (MIE ignored) -> RUN. If MIE = 1, RUN then takes the PEND path.
  - WFI_TIMEOUT != 0 and counter == WFI_TIMEOUT-1 -> RUN.
  - Counter clears on SLEEP entry and exit.
- Output exclusivity: intr and intr_end are never both high. Neither is ever high in a cycle where csr_we = 1. No pulse is issued while pipe_stall = 1.
- Latency: ext_irq rising at edge k with pend and safe held gives irq_q = 1 after k, PEND after k+1, and intr high for the cycle following edge k+2.
- pc_store holds its last value outside TRAP/RET.

Optional Feature:
- Macro: TRAP_CTRL_IRQ_SYNC_EN.
- Defined: ext_irq passes through a 2-flop synchronizer before irq_q. Entry latency grows by 2 cycles, and wake latency likewise.
- Undefined: ext_irq is assumed synchronous to clk and feeds irq_q directly.

Test Plan:
- Reset with ext_irq = 1, meie = mie = 1, then release rst: intr first high 3 cycles after release (ext_irq sampled at the first post-reset edge).
- Basic trap: meie = mie = 1, ex_valid = 1, ex_pc = 0x0000_0120, raise ext_irq -> intr = 1, redirect = 1, pc_store = 0x120 for exactly 1 cycle after 2 cycles; in_trap = 1 afterwards.
- Stall deferral: pipe_stall = 1 for 5 cycles during PEND -> no intr; intr fires the cycle after stall drops with pc_store = ex_pc at that time. Repeat with csr_we = 1 -> same deferral.
- Return: in HANDLER, mret = 1, ex_pc = 0x0001_0040 -> intr_end = 1, redirect = 1, pc_store = 0x0001_0044 for 1 cycle; state back to RUN; a 2nd irq while in HANDLER is ignored.
- Wrap: mret at ex_pc = 0xFFFF_FFFC -> pc_store = 0x0000_0000.
- WFI: WFI_TIMEOUT = 8, wfi & safe, no irq -> wfi_sleep high exactly 8 cycles then low. Second run with irq at cycle 3 (meie = 1, mie = 0) -> wake after irq_q, no intr.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry/return, WFI sleep and fetch redirect sequencing.
// Optional TRAP_CTRL_IRQ_SYNC_EN adds a 2-flop synchronizer on ext_irq ahead of irq_q.
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int WFI_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_irq,
  input  logic            csr_meie,
  input  logic            csr_mie,
  input  logic            csr_we,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            mret,
  input  logic            wfi,
  input  logic            pipe_stall,
  output logic            intr,
  output logic            intr_end,
  output logic [XLEN-1:0] pc_store,
  output logic            redirect,
  output logic            wfi_sleep,
  output logic            in_trap
);
  typedef enum logic [2:0] {RUN, PEND, TRAP, HANDLER, RET, SLEEP} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_store_q;
  logic [31:0]     cnt_q, cnt_d;
  logic            irq_in, irq_q, pend, safe, tmo;
  logic            intr_q, intr_end_q, redirect_q, wfi_sleep_q, in_trap_q;
`ifdef TRAP_CTRL_IRQ_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) sync_q <= rst ? 2'b00 : {sync_q[0], ext_irq};
  assign irq_in = sync_q[1];
`else
  assign irq_in = ext_irq;
`endif
  assign pend = irq_q & csr_meie & csr_mie;
  assign safe = ex_valid & ~pipe_stall & ~csr_we;
  assign tmo  = (WFI_TIMEOUT != 0) && (cnt_q == 32'(WFI_TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      RUN: begin
        if (mret && safe) begin
          state_d = RET;
          pc_d    = ex_pc + XLEN'(4);
        end else if (pend) state_d = PEND;
        else if (wfi && safe) state_d = SLEEP;
      end
      PEND: begin
        if (!pend) state_d = RUN;
        else if (safe) begin
          state_d = TRAP;
          pc_d    = ex_pc;
        end
      end
      TRAP: state_d = HANDLER;
      HANDLER: begin
        if (mret && safe) begin
          state_d = RET;
          pc_d    = ex_pc + XLEN'(4);
        end
      end
      RET:   state_d = RUN;
      SLEEP: state_d = ((irq_q && csr_meie) || tmo) ? RUN : SLEEP;
      default: state_d = RUN;
    endcase
    // counter only runs while staying asleep, so it clears on both entry and exit
    cnt_d = (state_q == SLEEP && state_d == SLEEP) ? cnt_q + 32'd1 : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= '0;
      pc_store_q  <= '0;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
      intr_q      <= 1'b0;
      intr_end_q  <= 1'b0;
      redirect_q  <= 1'b0;
      wfi_sleep_q <= 1'b0;
      in_trap_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_in;
      intr_q      <= state_d == TRAP;
      intr_end_q  <= state_d == RET;
      redirect_q  <= state_d == TRAP || state_d == RET;
      wfi_sleep_q <= state_d == SLEEP;
      in_trap_q   <= state_d == HANDLER;
      if (state_d == TRAP || state_d == RET) pc_store_q <= pc_d;
    end
  end
  assign intr      = intr_q;
  assign intr_end  = intr_end_q;
  assign redirect  = redirect_q;
  assign wfi_sleep = wfi_sleep_q;
  assign in_trap   = in_trap_q;
  assign pc_store  = pc_store_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl; expected pulses are queued at stimulus time.
module tb_trap_ctrl;
`ifdef TRAP_CTRL_IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        ext_irq = 1'b1, csr_meie = 1'b1, csr_mie = 1'b1, csr_we = 1'b0;
  logic        ex_valid = 1'b1, mret = 1'b0, wfi = 1'b0, pipe_stall = 1'b0;
  logic [31:0] ex_pc = 32'h100;
  logic        intr, intr_end, redirect, wfi_sleep, in_trap;
  logic [31:0] pc_store;
  int          cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {logic ret; logic [31:0] pc; int cyc;} exp_t;
  exp_t sb[$];
  trap_ctrl #(.XLEN(32), .WFI_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .csr_meie(csr_meie), .csr_mie(csr_mie),
    .csr_we(csr_we), .ex_valid(ex_valid), .ex_pc(ex_pc), .mret(mret), .wfi(wfi),
    .pipe_stall(pipe_stall), .intr(intr), .intr_end(intr_end), .pc_store(pc_store),
    .redirect(redirect), .wfi_sleep(wfi_sleep), .in_trap(in_trap)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic ret, input logic [31:0] pc, input int at);
    exp_t e;
    e.ret = ret;
    e.pc  = pc;
    e.cyc = at;
    sb.push_back(e);
  endtask
  task automatic do_ret(input logic [31:0] pc);
    ex_pc = pc;
    mret  = 1'b1;
    push(1'b1, pc + 32'd4, cyc + 1);
    tick(1);
    mret = 1'b0;
    tick(2);
    check("ret_in_trap", in_trap, 0);
    check("ret_redirect", redirect, 0);
  endtask
  always @(negedge clk) begin
    if (intr || intr_end) begin
      if (sb.size() == 0) check("unexp_pulse", {intr, intr_end}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", {intr, intr_end}, e.ret ? 2'b01 : 2'b10);
        check("pc_store", pc_store, e.pc);
        check("redirect", redirect, 1);
        check("pulse_cyc", cyc, e.cyc);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    tick(3);
    check("rst_intr", intr, 0);
    check("rst_intr_end", intr_end, 0);
    check("rst_redirect", redirect, 0);
    check("rst_wfi_sleep", wfi_sleep, 0);
    check("rst_in_trap", in_trap, 0);
    check("rst_pc_store", pc_store, 0);
    // release with irq already high
    rst = 1'b0;
    push(1'b0, 32'h100, cyc + 3 + SL);
    tick(3 + SL);
    ext_irq = 1'b0;
    tick(1);
    check("t1_in_trap", in_trap, 1);
    tick(2 + SL);
    do_ret(32'h0001_0040);
    // basic trap plus a second irq ignored inside the handler
    ex_pc = 32'h120;
    ext_irq = 1'b1;
    push(1'b0, 32'h120, cyc + 3 + SL);
    tick(3 + SL);
    ext_irq = 1'b0;
    tick(1);
    check("t2_in_trap", in_trap, 1);
    ext_irq = 1'b1;
    tick(4 + SL);
    check("t2_nested_in_trap", in_trap, 1);
    ext_irq = 1'b0;
    tick(2 + SL);
    do_ret(32'h200);
    // pipe_stall deferral
    pipe_stall = 1'b1;
    ex_pc = 32'h300;
    ext_irq = 1'b1;
    tick(2 + SL + 5);
    ex_pc = 32'h340;
    pipe_stall = 1'b0;
    push(1'b0, 32'h340, cyc + 1);
    tick(1);
    ext_irq = 1'b0;
    tick(1);
    check("t3_in_trap", in_trap, 1);
    tick(2 + SL);
    do_ret(32'h400);
    // csr_we deferral, then return that wraps the PC
    csr_we = 1'b1;
    ex_pc = 32'h500;
    ext_irq = 1'b1;
    tick(2 + SL + 5);
    ex_pc = 32'h544;
    csr_we = 1'b0;
    push(1'b0, 32'h544, cyc + 1);
    tick(1);
    ext_irq = 1'b0;
    tick(1);
    check("t4_in_trap", in_trap, 1);
    tick(2 + SL);
    do_ret(32'hFFFF_FFFC);
    // irq withdrawn while pending: no trap
    pipe_stall = 1'b1;
    ext_irq = 1'b1;
    tick(2 + SL + 2);
    ext_irq = 1'b0;
    tick(2 + SL);
    pipe_stall = 1'b0;
    tick(3);
    check("t5_in_trap", in_trap, 0);
    check("t5_redirect", redirect, 0);
    // WFI timeout
    wfi = 1'b1;
    tick(1);
    wfi = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (wfi_sleep) n++;
      tick(1);
    end
    check("t6_sleep_len", n, 8);
    check("t6_awake", wfi_sleep, 0);
    // WFI wake on irq with MIE clear
    csr_mie = 1'b0;
    wfi = 1'b1;
    tick(1);
    wfi = 1'b0;
    check("t7_asleep", wfi_sleep, 1);
    tick(2);
    ext_irq = 1'b1;
    tick(1 + SL);
    check("t7_still_asleep", wfi_sleep, 1);
    tick(1);
    check("t7_woken", wfi_sleep, 0);
    tick(3);
    check("t7_no_trap", in_trap, 0);
    ext_irq = 1'b0;
    tick(2 + SL);
    csr_mie = 1'b1;
    tick(2);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
